// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between an instruction fetch port and a data port.
// Data has priority; a waiting fetch is forced through after STARVE_MAX consecutive data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        stall_if,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD_IF, RD_D} state_t;

  state_t     state;
  logic [3:0] starve_cnt;
  logic       fetch_prio;

  assign fetch_prio = if_req && (starve_cnt == 4'(STARVE_MAX));

  // Everything is gated by rst so outputs stay at 0 while reset is held.
  always_comb begin
    d_gnt     = 1'b0;
    if_gnt    = 1'b0;
    stall_if  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (rst) begin
      d_gnt    = d_req && !fetch_prio;
      if_gnt   = if_req && !d_gnt;
      stall_if = if_req && !if_gnt;
      if (if_gnt) begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
        mem_be   = '1;
      end else if (d_gnt) begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_be    = d_be;
      end
    end
  end

  always_comb begin
    if_rvalid = rst && (state == RD_IF) && !if_flush;
    d_rvalid  = rst && (state == RD_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      if (if_gnt || !if_req)
        starve_cnt <= '0;
      else if (d_gnt && (starve_cnt != 4'(STARVE_MAX)))
        starve_cnt <= starve_cnt + 4'd1;

      if (if_gnt)
        state <= RD_IF;
      else if (d_gnt && !d_we)
        state <= RD_D;
      else
        state <= IDLE;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, a starvation sequence, and random traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int unsigned SM = 4;

  typedef struct packed {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] mem_rdata;
  } ins_t;

  typedef struct packed {
    logic        if_gnt;
    logic        d_gnt;
    logic        stall_if;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
  } outs_t;

  typedef struct {
    string name;
    ins_t  i;
    outs_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, stall_if, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .stall_if(stall_if),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  task automatic apply(input ins_t v);
    rst = v.rst; if_req = v.if_req; if_addr = v.if_addr; if_flush = v.if_flush;
    d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    d_be = v.d_be; mem_rdata = v.mem_rdata;
  endtask

  function automatic outs_t sample();
    outs_t o;
    o.if_gnt = if_gnt; o.d_gnt = d_gnt; o.stall_if = stall_if;
    o.if_rvalid = if_rvalid; o.if_rdata = if_rdata;
    o.d_rvalid = d_rvalid; o.d_rdata = d_rdata;
    o.mem_en = mem_en; o.mem_we = mem_we; o.mem_addr = mem_addr;
    o.mem_wdata = mem_wdata; o.mem_be = mem_be;
    return o;
  endfunction

  task automatic check(input string name, input outs_t got, input outs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input string n, input ins_t i, input outs_t o);
    vec_t v;
    v.name = n; v.i = i; v.o = o;
    vecs.push_back(v);
  endtask

  // Drive at the falling edge, compare shortly after, let the rising edge commit.
  task automatic cycle(input string name, input ins_t v, input outs_t exp);
    @(negedge clk);
    apply(v);
    #1;
    check(name, sample(), exp);
  endtask

  initial begin
    apply(ins_t'{default: '0});

    // Directed table: rows run back to back, each row is one clock cycle.
    add("reset_hold", ins_t'{rst:1'b0, if_req:1'b1, if_addr:32'h100, d_req:1'b1,
        d_addr:32'h200, d_be:4'hF, mem_rdata:32'h1234, default:'0},
        outs_t'{default:'0});
    add("fetch_grant", ins_t'{rst:1'b1, if_req:1'b1, if_addr:32'h100, default:'0},
        outs_t'{if_gnt:1'b1, mem_en:1'b1, mem_addr:32'h100, mem_be:4'hF, default:'0});
    add("fetch_rvalid", ins_t'{rst:1'b1, mem_rdata:32'h00500093, default:'0},
        outs_t'{if_rvalid:1'b1, if_rdata:32'h00500093, default:'0});
    add("conflict", ins_t'{rst:1'b1, if_req:1'b1, if_addr:32'h300, d_req:1'b1,
        d_addr:32'h200, d_be:4'hF, mem_rdata:32'h11, default:'0},
        outs_t'{d_gnt:1'b1, stall_if:1'b1, mem_en:1'b1, mem_addr:32'h200, mem_be:4'hF, default:'0});
    add("conflict_resp", ins_t'{rst:1'b1, mem_rdata:32'hCAFE0001, default:'0},
        outs_t'{d_rvalid:1'b1, d_rdata:32'hCAFE0001, default:'0});
    add("write", ins_t'{rst:1'b1, d_req:1'b1, d_we:1'b1, d_addr:32'h40,
        d_wdata:32'hDEADBEEF, d_be:4'b0011, mem_rdata:32'h22, default:'0},
        outs_t'{d_gnt:1'b1, mem_en:1'b1, mem_we:1'b1, mem_addr:32'h40,
        mem_wdata:32'hDEADBEEF, mem_be:4'b0011, default:'0});
    add("write_noresp", ins_t'{rst:1'b1, mem_rdata:32'h12345678, default:'0},
        outs_t'{default:'0});
    add("flush_grant", ins_t'{rst:1'b1, if_req:1'b1, if_addr:32'h104, default:'0},
        outs_t'{if_gnt:1'b1, mem_en:1'b1, mem_addr:32'h104, mem_be:4'hF, default:'0});
    add("flush_drop", ins_t'{rst:1'b1, if_flush:1'b1, mem_rdata:32'hAAAA5555, default:'0},
        outs_t'{default:'0});
    add("flush_idle_grant", ins_t'{rst:1'b1, if_flush:1'b1, d_req:1'b1, d_addr:32'h80,
        d_be:4'hF, mem_rdata:32'h77, default:'0},
        outs_t'{d_gnt:1'b1, mem_en:1'b1, mem_addr:32'h80, mem_be:4'hF, default:'0});
    add("flush_on_data_resp", ins_t'{rst:1'b1, if_flush:1'b1, mem_rdata:32'h99, default:'0},
        outs_t'{d_rvalid:1'b1, d_rdata:32'h99, default:'0});
    add("rst_mid_grant", ins_t'{rst:1'b1, d_req:1'b1, d_addr:32'h200, d_be:4'hF, default:'0},
        outs_t'{d_gnt:1'b1, mem_en:1'b1, mem_addr:32'h200, mem_be:4'hF, default:'0});
    add("rst_mid_hold", ins_t'{rst:1'b0, if_req:1'b1, d_req:1'b1, d_addr:32'h200,
        d_be:4'hF, mem_rdata:32'h5A5A, default:'0},
        outs_t'{default:'0});
    add("rst_release", ins_t'{rst:1'b1, mem_rdata:32'hFFFF, default:'0},
        outs_t'{default:'0});

    foreach (vecs[k]) cycle(vecs[k].name, vecs[k].i, vecs[k].o);

    // Starvation: both held high; SM data grants, then one fetch, repeating.
    for (int k = 0; k < 2 * (SM + 1); k++) begin
      ins_t  v;
      outs_t e;
      logic  fetch_now, fetch_prev;
      v = ins_t'{rst:1'b1, if_req:1'b1, if_addr:32'h100, d_req:1'b1, d_addr:32'h200,
                 d_wdata:32'h5, d_be:4'hF, default:'0};
      v.mem_rdata = 32'h1000 + 32'(k);
      fetch_now  = (k % (SM + 1)) == SM;
      fetch_prev = (k > 0) && (((k - 1) % (SM + 1)) == SM);
      e = outs_t'{default:'0};
      e.mem_en = 1'b1;
      e.mem_be = 4'hF;
      if (fetch_now) begin
        e.if_gnt = 1'b1; e.mem_addr = 32'h100;
      end else begin
        e.d_gnt = 1'b1; e.stall_if = 1'b1; e.mem_addr = 32'h200; e.mem_wdata = 32'h5;
      end
      if (fetch_prev) begin
        e.if_rvalid = 1'b1; e.if_rdata = v.mem_rdata;
      end else if (k > 0) begin
        e.d_rvalid = 1'b1; e.d_rdata = v.mem_rdata;
      end
      cycle($sformatf("starve_%0d", k), v, e);
    end

    // Random traffic against a transaction-level model.
    begin
      int unsigned waited;   // consecutive data grants while a fetch is pending
      int          resp_q[$]; // 1 = fetch read in flight, 2 = data read in flight
      waited = 0;
      for (int n = 0; n < 400; n++) begin
        ins_t  v;
        outs_t e;
        logic  fw, dw;
        v.rst       = (n == 0) ? 1'b0 : ($urandom_range(0, 29) != 0);
        v.if_req    = $urandom_range(0, 3) != 0;
        v.if_addr   = $urandom;
        v.if_flush  = $urandom_range(0, 3) == 0;
        v.d_req     = $urandom_range(0, 2) != 0;
        v.d_we      = $urandom_range(0, 3) == 0;
        v.d_addr    = $urandom;
        v.d_wdata   = $urandom;
        v.d_be      = 4'($urandom);
        v.mem_rdata = $urandom;
        e = outs_t'{default:'0};
        fw = 1'b0;
        dw = 1'b0;
        if (!v.rst) begin
          waited = 0;
          resp_q.delete();
        end else begin
          fw = v.if_req && (!v.d_req || waited >= SM);
          dw = v.d_req && !fw;
          e.if_gnt   = fw;
          e.d_gnt    = dw;
          e.stall_if = v.if_req && !fw;
          if (fw) begin
            e.mem_en = 1'b1; e.mem_addr = v.if_addr; e.mem_be = 4'hF;
          end else if (dw) begin
            e.mem_en = 1'b1; e.mem_we = v.d_we; e.mem_addr = v.d_addr;
            e.mem_wdata = v.d_wdata; e.mem_be = v.d_be;
          end
          if (resp_q.size() > 0) begin
            if (resp_q[0] == 1 && !v.if_flush) begin
              e.if_rvalid = 1'b1; e.if_rdata = v.mem_rdata;
            end else if (resp_q[0] == 2) begin
              e.d_rvalid = 1'b1; e.d_rdata = v.mem_rdata;
            end
          end
        end
        cycle("random", v, e);
        @(posedge clk);
        resp_q.delete();
        if (v.rst) begin
          if (fw) resp_q.push_back(1);
          else if (dw && !v.d_we) resp_q.push_back(2);
          if (!v.if_req || fw) waited = 0;
          else if (dw && waited < SM) waited++;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
